// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB bus arbiter: one-hot HGRANT plus HMASTER/HMASTLOCK for the slave-side mux.
// Grant is held through fixed-length bursts and locked sequences; all outputs registered.
module ahb_bus_arbiter #(
   parameter int NUM_MASTERS = 4,
   parameter int MW          = $clog2(NUM_MASTERS)
) (
   input  logic                   HCLK,
   input  logic                   HRESETn,
   input  logic [NUM_MASTERS-1:0] HBUSREQ,
   input  logic [NUM_MASTERS-1:0] HLOCK,
   input  logic [1:0]             HTRANS,
   input  logic [2:0]             HBURST,
   input  logic                   HREADY,
   input  logic                   HRESP,
   output logic [NUM_MASTERS-1:0] HGRANT,
   output logic [MW-1:0]          HMASTER,
   output logic                   HMASTLOCK
);

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;

   typedef enum logic [1:0] {
      ST_PARK,
      ST_OWN,
      ST_BURST,
      ST_LOCKED
   } st_t;

   st_t                   st;
   st_t                   st_nxt;
   logic [3:0]            bcnt;
   logic [3:0]            next_bcnt;
   logic [MW-1:0]         g;
   logic                  lock_hold;
   logic                  acc;
   logic                  arb_pt;
   logic                  found;
   logic [MW-1:0]         cand;
   logic [MW-1:0]         own_idx;
   logic [NUM_MASTERS-1:0] grant_d;

   // Beats remaining after the NONSEQ of a fixed-length burst; undefined-length INCR counts as SINGLE.
   function automatic logic [3:0] burst_last(input logic [2:0] b);
      case (b[2:1])
         2'b00:   burst_last = 4'd0;
         2'b01:   burst_last = 4'd3;
         2'b10:   burst_last = 4'd7;
         default: burst_last = 4'd15;
      endcase
   endfunction

   always_comb begin
      g = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (HGRANT[i]) g = MW'(i);
      end
   end

   assign lock_hold = HLOCK[g];
   assign acc       = HREADY && (HTRANS == TR_NONSEQ || HTRANS == TR_SEQ);

   always_comb begin
      next_bcnt = bcnt;
      if (HREADY && (HRESP || HTRANS == TR_IDLE)) begin
         next_bcnt = 4'd0;
      end else if (acc && HTRANS == TR_NONSEQ) begin
         next_bcnt = burst_last(HBURST);
      end else if (acc && HTRANS == TR_SEQ && bcnt != 4'd0) begin
         next_bcnt = bcnt - 4'd1;
      end
   end

   assign arb_pt = HREADY && (next_bcnt == 4'd0) && !lock_hold;

   // Search starts just after the current owner and wraps back to it, so the owner is considered last.
   always_comb begin
      found   = 1'b0;
      own_idx = g;
      cand    = g;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         cand = MW'((int'(g) + k) % NUM_MASTERS);
         if (!found && HBUSREQ[cand]) begin
            found   = 1'b1;
            own_idx = cand;
         end
      end
      grant_d = NUM_MASTERS'(1) << own_idx;
   end

   always_comb begin
      st_nxt = st;
      if (HREADY && lock_hold) begin
         st_nxt = ST_LOCKED;
      end else if (next_bcnt != 4'd0) begin
         st_nxt = ST_BURST;
      end else if (arb_pt) begin
         st_nxt = HBUSREQ[own_idx] ? ST_OWN : ST_PARK;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         HGRANT    <= NUM_MASTERS'(1);
         HMASTER   <= '0;
         HMASTLOCK <= 1'b0;
         bcnt      <= 4'd0;
         st        <= ST_PARK;
      end else begin
         bcnt <= next_bcnt;
         st   <= st_nxt;
         if (arb_pt) HGRANT <= grant_d;
         // Address phase ownership only advances when the previous phase completes.
         if (HREADY) begin
            HMASTER   <= g;
            HMASTLOCK <= lock_hold;
         end
      end
   end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed scenarios plus random traffic for ahb_bus_arbiter, checked against a behavioural model.
module tb_ahb_bus_arbiter;

   logic       HCLK = 1'b0;
   logic       HRESETn = 1'b0;
   logic [3:0] HBUSREQ = '0;
   logic [3:0] HLOCK = '0;
   logic [1:0] HTRANS = 2'b00;
   logic [2:0] HBURST = 3'b000;
   logic       HREADY = 1'b1;
   logic       HRESP = 1'b0;
   logic [3:0] HGRANT;
   logic [1:0] HMASTER;
   logic       HMASTLOCK;

   int total = 0;
   int passed = 0;

   // Reference model state
   int m_g = 0;
   int m_bcnt = 0;
   int m_master = 0;
   bit m_mlock = 1'b0;

   ahb_bus_arbiter #(.NUM_MASTERS(4)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
      .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY), .HRESP(HRESP),
      .HGRANT(HGRANT), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
   );

   always #5 HCLK = ~HCLK;

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
   endtask

   function automatic int burst_len(input logic [2:0] b);
      case (b)
         3'b010, 3'b011: return 4;
         3'b100, 3'b101: return 8;
         3'b110, 3'b111: return 16;
         default:        return 1;
      endcase
   endfunction

   task automatic model_reset();
      m_g = 0; m_bcnt = 0; m_master = 0; m_mlock = 1'b0;
   endtask

   // One bus edge as seen by the specification's rules.
   task automatic model_edge();
      int  nb;
      bit  held;
      held = HLOCK[m_g];
      if (HREADY && (HRESP || HTRANS == 2'b00))       nb = 0;
      else if (HREADY && HTRANS == 2'b10)             nb = burst_len(HBURST) - 1;
      else if (HREADY && HTRANS == 2'b11 && m_bcnt > 0) nb = m_bcnt - 1;
      else                                            nb = m_bcnt;
      if (HREADY) begin
         m_master = m_g;
         m_mlock  = held;
      end
      if (HREADY && nb == 0 && !held) begin
         for (int k = 1; k <= 4; k++) begin
            if (HBUSREQ[(m_g + k) % 4]) begin
               m_g = (m_g + k) % 4;
               break;
            end
         end
      end
      m_bcnt = nb;
   endtask

   task automatic check_all(input string tag);
      check({tag, "_grant"}, 32'(HGRANT), 32'(1) << m_g);
      check({tag, "_master"}, 32'(HMASTER), 32'(m_master));
      check({tag, "_mlock"}, 32'(HMASTLOCK), 32'(m_mlock));
      check({tag, "_bcnt"}, 32'(dut.bcnt), 32'(m_bcnt));
      check({tag, "_onehot"}, 32'($onehot(HGRANT)), 32'd1);
   endtask

   task automatic step(input string tag, input logic [3:0] req, input logic [3:0] lk,
                       input logic [1:0] tr, input logic [2:0] bu,
                       input logic rdy, input logic rsp);
      HBUSREQ = req; HLOCK = lk; HTRANS = tr; HBURST = bu; HREADY = rdy; HRESP = rsp;
      @(posedge HCLK);
      model_edge();
      #1;
      check_all(tag);
   endtask

   initial begin
      // Reset default
      repeat (2) @(posedge HCLK);
      #1;
      model_reset();
      check_all("rst_hold");
      HRESETn = 1'b1;
      for (int i = 0; i < 10; i++) step("park", 4'b0000, 4'b0000, 2'b00, 3'b000, 1'b1, 1'b0);
      check("park_grant", 32'(HGRANT), 32'h1);

      // Round robin with all masters requesting SINGLE transfers
      begin
         logic [3:0] rr_tbl [4];
         rr_tbl = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
         for (int i = 0; i < 4; i++) begin
            step("rr", 4'b1111, 4'b0000, 2'b10, 3'b000, 1'b1, 1'b0);
            check("rr_tbl", 32'(HGRANT), 32'(rr_tbl[i]));
         end
      end

      // Burst hold: master 1 INCR4 with a BUSY and a wait state while master 2 requests
      step("b_get", 4'b0010, 4'b0000, 2'b00, 3'b000, 1'b1, 1'b0);
      step("b_nseq", 4'b0110, 4'b0000, 2'b10, 3'b011, 1'b1, 1'b0);
      step("b_seq1", 4'b0110, 4'b0000, 2'b11, 3'b011, 1'b1, 1'b0);
      step("b_busy", 4'b0110, 4'b0000, 2'b01, 3'b011, 1'b1, 1'b0);
      step("b_wait", 4'b0110, 4'b0000, 2'b11, 3'b011, 1'b0, 1'b0);
      step("b_seq2", 4'b0110, 4'b0000, 2'b11, 3'b011, 1'b1, 1'b0);
      check("b_hold", 32'(HGRANT), 32'h2);
      step("b_seq3", 4'b0110, 4'b0000, 2'b11, 3'b011, 1'b1, 1'b0);
      check("b_handover", 32'(HGRANT), 32'h4);
      step("b_next", 4'b0100, 4'b0000, 2'b10, 3'b000, 1'b1, 1'b0);
      check("b_hmaster", 32'(HMASTER), 32'd2);

      // Locked sequence by master 3
      step("l_get", 4'b1000, 4'b0000, 2'b00, 3'b000, 1'b1, 1'b0);
      step("l_s1", 4'b1111, 4'b1000, 2'b10, 3'b000, 1'b1, 1'b0);
      step("l_s2", 4'b1111, 4'b1000, 2'b10, 3'b000, 1'b1, 1'b0);
      check("l_hold", 32'(HGRANT), 32'h8);
      check("l_mlock", 32'(HMASTLOCK), 32'd1);
      step("l_drop", 4'b0111, 4'b0000, 2'b00, 3'b000, 1'b1, 1'b0);
      check("l_release", 32'(HGRANT), 32'h1);

      // Error abort on beat 2 of a WRAP8
      step("e_park", 4'b0001, 4'b0000, 2'b00, 3'b000, 1'b1, 1'b0);
      step("e_nseq", 4'b0011, 4'b0000, 2'b10, 3'b100, 1'b1, 1'b0);
      step("e_seq", 4'b0011, 4'b0000, 2'b11, 3'b100, 1'b1, 1'b0);
      step("e_err1", 4'b0011, 4'b0000, 2'b11, 3'b100, 1'b0, 1'b1);
      check("e_err1_grant", 32'(HGRANT), 32'h1);
      step("e_err2", 4'b0011, 4'b0000, 2'b00, 3'b100, 1'b1, 1'b1);
      check("e_err2_grant", 32'(HGRANT), 32'h2);
      check("e_err2_bcnt", 32'(dut.bcnt), 32'd0);

      // Asynchronous reset in the middle of an INCR16
      step("r_nseq", 4'b0110, 4'b0000, 2'b10, 3'b111, 1'b1, 1'b0);
      step("r_seq1", 4'b0110, 4'b0000, 2'b11, 3'b111, 1'b1, 1'b0);
      step("r_seq2", 4'b0110, 4'b0000, 2'b11, 3'b111, 1'b1, 1'b0);
      #2 HRESETn = 1'b0;
      #1;
      model_reset();
      check_all("r_async");
      @(posedge HCLK);
      #2 HRESETn = 1'b1;
      check_all("r_held");
      step("r_first", 4'b1111, 4'b0000, 2'b00, 3'b000, 1'b1, 1'b0);
      check("r_first_grant", 32'(HGRANT), 32'h2);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         step("rnd", 4'($urandom),
              ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000,
              2'($urandom), 3'($urandom),
              1'($urandom_range(0, 4) != 0),
              1'($urandom_range(0, 9) == 0));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
